survivor_traceback: RTL

Survivor-path controller for the Viterbi decoder, sitting between the add-compare-select (ACS) stage and the survivor RAM. Per trellis step it writes the ACS 8-bit decision word (one survivor bit per state, 8 states, K=4) into the RAM over the shared bidirectional bus. At each frame end it traces back through the stored words from the ACS best state and emits the decoded bits in forward order through a valid/ready port.

---
 rtl/survivor_traceback_pkg.sv | 24 ++
 rtl/survivor_traceback_tb_reverse_buf.sv | 27 ++
 rtl/survivor_traceback.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/survivor_traceback_pkg.sv
// Shared widths, FSM encoding and trellis helper for the Viterbi survivor-path controller.
package survivor_traceback_pkg;

  localparam int unsigned WD_RAM_ADDRESS = 4;
  localparam int unsigned NUM_STATES     = 8;
  localparam int unsigned WD_STATE       = 3;
  localparam int unsigned WD_DECISION    = NUM_STATES;

  typedef enum logic [1:0] {
    ST_WRITE   = 2'd0,
    ST_TB_ADDR = 2'd1,
    ST_TB_DATA = 2'd2,
    ST_OUTPUT  = 2'd3
  } tb_fsm_e;

  // State s = {u(t-1), u(t-2), u(t-3)}; the survivor bit recovers the oldest input bit.
  function automatic logic [WD_STATE-1:0] tb_predecessor(
    input logic [WD_STATE-1:0]    s,
    input logic [WD_DECISION-1:0] w
  );
    return {s[WD_STATE-2:0], w[s]};
  endfunction

endpackage

// File: rtl/survivor_traceback_tb_reverse_buf.sv
// Frame-length bit buffer: traceback fills it newest-first, output drains it oldest-first.
module tb_reverse_buf #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_bit,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_bit
);

  logic [FRAME_LEN-1:0] bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits <= '0;
    end else if (wr_en) begin
      bits[wr_idx] <= wr_bit;
    end
  end

  assign rd_bit = bits[rd_idx];

endmodule

// File: rtl/survivor_traceback.sv
// Survivor-path controller: stores ACS decision words in the survivor RAM, then traces
// back from the best state at frame end and streams the decoded bits in forward order.
module survivor_traceback
  import survivor_traceback_pkg::*;
#(
  parameter int unsigned ADDR_W    = WD_RAM_ADDRESS,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [WD_DECISION-1:0] DecisionIn,
  input  logic                   DecisionValid,
  output logic                   DecisionReady,
  input  logic [WD_STATE-1:0]    BestState,
  output logic                   RAMEnable,
  output logic                   RWSelect,
  output logic [ADDR_W-1:0]      AddressRAM,
  inout  wire  [WD_DECISION-1:0] DataRAM,
  output logic                   BitOut,
  output logic                   BitValid,
  input  logic                   BitReady,
  output logic                   FrameDone
);

  localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);

  tb_fsm_e             state, next_state;
  logic [ADDR_W-1:0]   wr_cnt, next_wr_cnt;
  logic [ADDR_W-1:0]   tb_addr, next_tb_addr;
  logic [IDX_W-1:0]    out_idx, next_out_idx;
  logic [WD_STATE-1:0] tb_state, next_tb_state;
  logic [WD_STATE-1:0] tb_pred;
  logic                bus_drive;
  logic                rev_wr_en;
  logic                rev_bit;

  // Kept outside the FSM block so the bus driver does not loop through the read path.
  assign bus_drive = (state == ST_WRITE) && DecisionValid;
  assign DataRAM   = bus_drive ? DecisionIn : {WD_DECISION{1'bz}};
  assign tb_pred   = tb_predecessor(tb_state, DataRAM);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= ST_WRITE;
      wr_cnt   <= '0;
      tb_addr  <= '0;
      out_idx  <= '0;
      tb_state <= '0;
    end else begin
      state    <= next_state;
      wr_cnt   <= next_wr_cnt;
      tb_addr  <= next_tb_addr;
      out_idx  <= next_out_idx;
      tb_state <= next_tb_state;
    end
  end

  always_comb begin
    next_state    = state;
    next_wr_cnt   = wr_cnt;
    next_tb_addr  = tb_addr;
    next_out_idx  = out_idx;
    next_tb_state = tb_state;
    DecisionReady = 1'b0;
    RAMEnable     = 1'b1;
    RWSelect      = 1'b1;
    AddressRAM    = wr_cnt;
    BitValid      = 1'b0;
    BitOut        = 1'b0;
    FrameDone     = 1'b0;
    rev_wr_en     = 1'b0;

    case (state)
      ST_WRITE: begin
        DecisionReady = 1'b1;
        if (DecisionValid) begin
          RAMEnable = 1'b0;
          RWSelect  = 1'b0;
          if (wr_cnt == LAST_ADDR) begin
            next_tb_state = BestState;
            next_tb_addr  = LAST_ADDR;
            next_state    = ST_TB_ADDR;
          end else begin
            next_wr_cnt = wr_cnt + ADDR_W'(1);
          end
        end
      end

      ST_TB_ADDR: begin
        RAMEnable  = 1'b0;
        AddressRAM = tb_addr;
        next_state = ST_TB_DATA;
      end

      // Read word is on the bus at the edge that ends this cycle.
      ST_TB_DATA: begin
        AddressRAM    = tb_addr;
        rev_wr_en     = 1'b1;
        next_tb_state = tb_pred;
        if (tb_addr == '0) begin
          next_out_idx = '0;
          next_state   = ST_OUTPUT;
        end else begin
          next_tb_addr = tb_addr - ADDR_W'(1);
          next_state   = ST_TB_ADDR;
        end
      end

      ST_OUTPUT: begin
        BitValid = 1'b1;
        BitOut   = rev_bit;
        if (BitReady) begin
          if (out_idx == LAST_IDX) begin
            FrameDone   = 1'b1;
            next_wr_cnt = '0;
            next_state  = ST_WRITE;
          end else begin
            next_out_idx = out_idx + IDX_W'(1);
          end
        end
      end

      default: next_state = ST_WRITE;
    endcase
  end

  tb_reverse_buf #(
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_rev_buf (
    .clk    (Clock),
    .rst    (Reset),
    .wr_en  (rev_wr_en),
    .wr_idx (IDX_W'(tb_addr)),
    .wr_bit (tb_state[WD_STATE-1]),
    .rd_idx (out_idx),
    .rd_bit (rev_bit)
  );

endmodule
